// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform parameter controller.
package wave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      WAIT_WRAP,
      COMMIT,
      ACK
   } state_t;

   typedef struct packed {
      logic [7:0]  ch;
      logic [31:0] adder;
      logic [31:0] ampl;
   } frame_t;

   localparam logic [7:0]  ACK_OK    = 8'h6B;
   localparam logic [7:0]  ACK_ERR   = 8'h6E;
   localparam logic [31:0] DEF_ADDER = 32'd214748;
   localparam logic [31:0] DEF_AMPL  = 32'd255;

endpackage

// File: rtl/wave_param_ctrl.sv
// Per-channel DDS parameter controller: shadows a UART frame and commits it on the channel's phase wrap.
// Define WAVE_PARAM_ACK_EN to return an 'k'/'n' response byte per frame.
module wave_param_ctrl #(
   parameter int NUM_CH  = 4,
   parameter int WRAP_TO = 65535
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [7:0]           cmd_ch,
   input  logic [31:0]          cmd_adder,
   input  logic [31:0]          cmd_ampl,
   input  logic [NUM_CH-1:0]    ch_wrap,
   output logic [NUM_CH*32-1:0] ch_adder,
   output logic [NUM_CH*32-1:0] ch_ampl,
   output logic [NUM_CH-1:0]    upd_pending,
   output logic                 ack_valid,
   input  logic                 ack_ready,
   output logic [7:0]           ack_data,
   output logic [7:0]           err_cnt
);
   import wave_pkg::*;

   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CW  = (WRAP_TO > 0) ? $clog2(WRAP_TO + 1) : 1;
   localparam logic [CW-1:0] WAIT_MAX = CW'(WRAP_TO);

   state_t                   state;
   frame_t                   hold;
   logic [CW-1:0]            wait_cnt;
   logic [NUM_CH-1:0][31:0]  act_adder, act_ampl;
   logic [NUM_CH-1:0][31:0]  sh_adder, sh_ampl;
   logic                     ch_ok;
   logic [CHW-1:0]           ch_idx;

   assign ch_ok    = (32'(hold.ch) < 32'(NUM_CH));
   assign ch_idx   = hold.ch[CHW-1:0];
   assign ch_adder = act_adder;
   assign ch_ampl  = act_ampl;

`ifdef WAVE_PARAM_ACK_EN
   logic       ack_valid_r;
   logic [7:0] ack_data_r;
   assign ack_valid = ack_valid_r;
   assign ack_data  = ack_data_r;
`else
   logic unused_ack_ready;
   assign unused_ack_ready = ack_ready;
   assign ack_valid = 1'b0;
   assign ack_data  = 8'h00;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cmd_ready   <= 1'b0;
         hold        <= '0;
         wait_cnt    <= '0;
         act_adder   <= {NUM_CH{DEF_ADDER}};
         act_ampl    <= {NUM_CH{DEF_AMPL}};
         sh_adder    <= {NUM_CH{DEF_ADDER}};
         sh_ampl     <= {NUM_CH{DEF_AMPL}};
         upd_pending <= '0;
         err_cnt     <= 8'h00;
`ifdef WAVE_PARAM_ACK_EN
         ack_valid_r <= 1'b0;
         ack_data_r  <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  hold      <= '{ch: cmd_ch, adder: cmd_adder, ampl: cmd_ampl};
                  cmd_ready <= 1'b0;
                  state     <= CHECK;
               end
            end
            CHECK: begin
               if (!ch_ok) begin
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef WAVE_PARAM_ACK_EN
                  ack_data_r  <= ACK_ERR;
                  ack_valid_r <= 1'b1;
                  state       <= ACK;
`else
                  cmd_ready   <= 1'b1;
                  state       <= IDLE;
`endif
               end else begin
                  sh_adder[ch_idx]    <= hold.adder;
                  sh_ampl[ch_idx]     <= hold.ampl;
                  upd_pending[ch_idx] <= 1'b1;
                  wait_cnt            <= '0;
                  state               <= WAIT_WRAP;
               end
            end
            WAIT_WRAP: begin
               // Only the held channel's wrap matters; the timeout bounds a stalled accumulator.
               if (ch_wrap[ch_idx] || wait_cnt == WAIT_MAX) state <= COMMIT;
               else wait_cnt <= wait_cnt + 1'b1;
            end
            COMMIT: begin
               act_adder[ch_idx]   <= sh_adder[ch_idx];
               act_ampl[ch_idx]    <= sh_ampl[ch_idx];
               upd_pending[ch_idx] <= 1'b0;
`ifdef WAVE_PARAM_ACK_EN
               ack_data_r  <= ACK_OK;
               ack_valid_r <= 1'b1;
               state       <= ACK;
`else
               cmd_ready   <= 1'b1;
               state       <= IDLE;
`endif
            end
`ifdef WAVE_PARAM_ACK_EN
            ACK: begin
               if (ack_ready) begin
                  ack_valid_r <= 1'b0;
                  cmd_ready   <= 1'b1;
                  state       <= IDLE;
               end
            end
`endif
            default: begin
               cmd_ready <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wave_param_ctrl.sv
// Scoreboard bench for wave_param_ctrl: lane updates and response bytes are queued at drive time.
module tb_wave_param_ctrl;
   localparam int NUM_CH  = 4;
   localparam int WRAP_TO = 16;
   localparam logic [31:0] DEF_AD = 32'd214748;
   localparam logic [31:0] DEF_AM = 32'd255;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 cmd_valid = 1'b0;
   logic                 cmd_ready;
   logic [7:0]           cmd_ch = 8'h00;
   logic [31:0]          cmd_adder = 32'h0;
   logic [31:0]          cmd_ampl = 32'h0;
   logic [NUM_CH-1:0]    ch_wrap = '0;
   logic [NUM_CH*32-1:0] ch_adder, ch_ampl;
   logic [NUM_CH-1:0]    upd_pending;
   logic                 ack_valid;
   logic                 ack_ready = 1'b1;
   logic [7:0]           ack_data;
   logic [7:0]           err_cnt;

   wave_param_ctrl #(.NUM_CH(NUM_CH), .WRAP_TO(WRAP_TO)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_adder(cmd_adder), .cmd_ampl(cmd_ampl), .ch_wrap(ch_wrap),
      .ch_adder(ch_adder), .ch_ampl(ch_ampl), .upd_pending(upd_pending),
      .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_data(ack_data), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int          ch;
      logic [31:0] ad;
      logic [31:0] am;
      int          cyc;
   } upd_t;

   upd_t                 exp_q[$];
   logic [7:0]           ack_q[$];
   logic [NUM_CH*32-1:0] mdl_ad, mdl_am, prev_ad, prev_am;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_lanes(input string tag);
      for (int i = 0; i < NUM_CH; i++) begin
         chk($sformatf("%s_adder%0d", tag, i), ch_adder[i*32 +: 32], mdl_ad[i*32 +: 32]);
         chk($sformatf("%s_ampl%0d", tag, i), ch_ampl[i*32 +: 32], mdl_am[i*32 +: 32]);
      end
   endtask

   // Enter at posedge+1; leave at posedge+1 just after the accept edge.
   task automatic send(input logic [7:0] ch, input logic [31:0] ad, input logic [31:0] am,
                       input int lat, output int acc);
      int t;
      upd_t e;
      t = 0;
      cmd_valid = 1'b1; cmd_ch = ch; cmd_adder = ad; cmd_ampl = am;
      do begin
         @(negedge clk);
         t++;
      end while (!cmd_ready && t < 200);
      chk("accept_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      acc = cyc;
      cmd_valid = 1'b0;
      if (32'(ch) < 32'(NUM_CH)) begin
         e.ch = int'(ch); e.ad = ad; e.am = am; e.cyc = acc + lat;
         exp_q.push_back(e);
         mdl_ad[int'(ch)*32 +: 32] = ad;
         mdl_am[int'(ch)*32 +: 32] = am;
      end
`ifdef WAVE_PARAM_ACK_EN
      ack_q.push_back((32'(ch) < 32'(NUM_CH)) ? 8'h6B : 8'h6E);
`endif
   endtask

   task automatic pulse_wrap(input int ch, input int d);
      repeat (d) @(posedge clk);
      if (d > 0) #1;
      ch_wrap[ch] = 1'b1;
      @(posedge clk); #1;
      ch_wrap = '0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(cmd_ready && exp_q.size() == 0 && ack_q.size() == 0) && t < 300);
      chk("idle_reached", 32'(cmd_ready && exp_q.size() == 0 && ack_q.size() == 0), 32'd1);
      @(posedge clk); #1;
   endtask

   // Monitor: every lane change must match the head of the update queue, on the predicted cycle.
   initial begin
      upd_t e;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (ch_adder[i*32 +: 32] !== prev_ad[i*32 +: 32] ||
                   ch_ampl[i*32 +: 32] !== prev_am[i*32 +: 32]) begin
                  chk("upd_expected", 32'(exp_q.size() > 0), 32'd1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     chk("upd_lane", 32'(i), 32'(e.ch));
                     chk("upd_adder", ch_adder[i*32 +: 32], e.ad);
                     chk("upd_ampl", ch_ampl[i*32 +: 32], e.am);
                     chk("upd_cycle", 32'(cyc), 32'(e.cyc));
                  end
               end
            end
`ifdef WAVE_PARAM_ACK_EN
            if (ack_valid && ack_ready) begin
               chk("ack_expected", 32'(ack_q.size() > 0), 32'd1);
               if (ack_q.size() > 0) begin
                  b = ack_q.pop_front();
                  chk("ack_data", 32'(ack_data), 32'(b));
               end
            end
`endif
         end
         prev_ad = ch_adder;
         prev_am = ch_ampl;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      mdl_ad = {NUM_CH{DEF_AD}};
      mdl_am = {NUM_CH{DEF_AM}};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_lanes("rst");
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_pending", 32'(upd_pending), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_ack_valid", 32'(ack_valid), 32'd0);
      chk("rst_ack_data", 32'(ack_data), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;

      // Wrap pulses while idle are ignored
      ch_wrap = '1;
      repeat (2) @(posedge clk);
      #1 ch_wrap = '0;
      @(negedge clk);
      chk("idle_wrap_pending", 32'(upd_pending), 32'd0);
      @(posedge clk); #1;

      // ch2: wrap 10 cycles after accept -> update 12 edges after accept
      send(8'd2, 32'h0001_0000, 32'd100, 12, acc);
      repeat (4) @(negedge clk);
      chk("ch2_pending", 32'(upd_pending), 32'h4);
      chk("ch2_busy_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      pulse_wrap(2, acc + 10 - cyc);
      wait_idle();
      chk_lanes("ch2");
      chk("ch2_pending_clr", 32'(upd_pending), 32'd0);

      // ch7 out of range: rejected, counted, no lane touched
      send(8'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, acc);
      wait_idle();
      chk("bad_err_cnt", 32'(err_cnt), 32'd1);
      chk("bad_pending", 32'(upd_pending), 32'd0);
      chk_lanes("bad");

      // ch1 never wraps: forced commit at WRAP_TO+3
      send(8'd1, 32'h1234_5678, 32'h0000_ABCD, WRAP_TO + 3, acc);
      repeat (8) @(negedge clk);
      chk("ch1_pending", 32'(upd_pending), 32'h2);
      chk("ch1_busy_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      wait_idle();
      chk_lanes("ch1");

      // ch3: wrap during CHECK and wrap on another channel are both ignored
      send(8'd3, 32'h0BAD_F00D, 32'd3, WRAP_TO + 3, acc);
      pulse_wrap(3, 0);
      pulse_wrap(0, 2);
      wait_idle();
      chk_lanes("ch3");

      // ch1 minimum latency: wrap on first WAIT_WRAP cycle
      send(8'd1, 32'h0000_0042, 32'd77, 3, acc);
      pulse_wrap(1, 1);
      wait_idle();
      chk_lanes("ch1min");

`ifdef WAVE_PARAM_ACK_EN
      // Response held off: ack stays valid, a second frame is refused
      ack_ready = 1'b0;
      send(8'd2, 32'h0000_0777, 32'd7, 3, acc);
      pulse_wrap(2, 1);
      cmd_valid = 1'b1; cmd_ch = 8'd3; cmd_adder = 32'h5; cmd_ampl = 32'h6;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i >= 2 && i % 8 == 0) begin
            chk("hold_ack_valid", 32'(ack_valid), 32'd1);
            chk("hold_ack_data", 32'(ack_data), 32'h6B);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      ack_ready = 1'b1;
      wait_idle();
      chk_lanes("hold");
`else
      ack_ready = 1'b1;
      @(negedge clk);
      chk("tied_ack_valid", 32'(ack_valid), 32'd0);
      chk("tied_ack_data", 32'(ack_data), 32'd0);
      @(posedge clk); #1;
`endif

      // err_cnt saturates at 255, covering ch = NUM_CH .. 255
      for (int k = 0; k < 260; k++) begin
         send(8'(NUM_CH + (k % (256 - NUM_CH))), 32'h1, 32'h1, 0, acc);
         wait_idle();
      end
      chk("sat_err_cnt", 32'(err_cnt), 32'd255);
      chk_lanes("sat");

      // Reset in WAIT_WRAP discards the frame
      send(8'd0, 32'hDEAD_0000, 32'h55, WRAP_TO + 3, acc);
      repeat (5) @(negedge clk);
      chk("mid_pending", 32'(upd_pending), 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      ack_q.delete();
      mdl_ad = {NUM_CH{DEF_AD}};
      mdl_am = {NUM_CH{DEF_AM}};
      @(negedge clk);
      chk_lanes("mid_rst");
      chk("mid_rst_pending", 32'(upd_pending), 32'd0);
      chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (30) @(negedge clk);
      chk("mid_after_pending", 32'(upd_pending), 32'd0);
      chk_lanes("mid_after");
      @(posedge clk); #1;

      // Fresh frame after reset commits normally
      send(8'd0, 32'h0000_1111, 32'd9, 4, acc);
      pulse_wrap(0, 2);
      wait_idle();
      chk_lanes("post");

      chk("sb_upd_empty", 32'(exp_q.size()), 32'd0);
      chk("sb_ack_empty", 32'(ack_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
